// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared encodings and defaults for the bit-serial arithmetic cells
package arith_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // 2'd3 is unused and recovers to IDLE in the FSM
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - one-bit full subtractor cell, d = x - y - bin
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial WIDTH-bit subtractor behind a start/done handshake
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, res_q, diff_q;
  logic [CW-1:0]    cnt_q;
  logic             bin_q, borrow_q;
  logic             d_bit, bout_bit, last_bit;

  full_subtractor u_fs (
    .x    (a_q[0]),
    .y    (b_q[0]),
    .bin  (bin_q),
    .d    (d_bit),
    .bout (bout_bit)
  );

  assign last_bit = (state_q == SHIFT) && (cnt_q == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_bit) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The counter holds at WIDTH-1 on the last bit so it never wraps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      bin_q    <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            bin_q <= 1'b0;
            cnt_q <= '0;
          end
        end
        SHIFT: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          res_q <= {d_bit, res_q[WIDTH-1:1]};
          bin_q <= bout_bit;
          if (last_bit) begin
            diff_q   <= {d_bit, res_q[WIDTH-1:1]};
            borrow_q <= bout_bit;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign diff       = diff_q;
  assign borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed and swept checks of serial_subtractor at WIDTH 8 and 13
module tb_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start8, start13;
  logic [7:0]  a8, b8, diff8;
  logic [12:0] a13, b13, diff13;
  logic        busy8, done8, bo8, busy13, done13, bo13;
  logic        fs_x, fs_y, fs_bin, fs_d, fs_bout;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8)
  );

  serial_subtractor #(.WIDTH(13)) dut13 (
    .clk(clk), .rst_n(rst_n), .start(start13), .a(a13), .b(b13),
    .busy(busy13), .done(done13), .diff(diff13), .borrow_out(bo13)
  );

  full_subtractor u_fs (
    .x(fs_x), .y(fs_y), .bin(fs_bin), .d(fs_d), .bout(fs_bout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run8(input logic [7:0] av, input logic [7:0] bv,
                      input logic [7:0] ed, input logic eb, input string tag);
    int cyc;
    bit seen;
    a8 = av; b8 = bv; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    check({tag, ".busy"}, 32'(busy8), 32'd1);
    cyc = 0; seen = 0;
    while (!seen && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (done8) seen = 1;
    end
    check({tag, ".latency"}, 32'(cyc), 32'd8);
    check({tag, ".diff"}, 32'(diff8), 32'(ed));
    check({tag, ".borrow"}, 32'(bo8), 32'(eb));
    @(posedge clk); #1;
    check({tag, ".done_low"}, 32'(done8), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   ndone, dpos, gap, r;
    bit   seen, any_done;
    logic [7:0]  ea8, eb8;
    logic [12:0] ea13, eb13;

    rst_n = 1'b0; start8 = 1'b0; start13 = 1'b0;
    a8 = '0; b8 = '0; a13 = '0; b13 = '0;
    fs_x = 1'b0; fs_y = 1'b0; fs_bin = 1'b0;

    for (int k = 0; k < 8; k++) begin
      {fs_x, fs_y, fs_bin} = 3'(k);
      #1;
      r = int'(fs_x) - int'(fs_y) - int'(fs_bin);
      check($sformatf("fs%0d.d", k), 32'(fs_d), 32'(r & 1));
      check($sformatf("fs%0d.bout", k), 32'(fs_bout), 32'(r < 0));
    end

    repeat (3) @(posedge clk);
    #1;
    check("rst.busy", 32'(busy8), 32'd0);
    check("rst.done", 32'(done8), 32'd0);
    check("rst.diff", 32'(diff8), 32'd0);
    check("rst.borrow", 32'(bo8), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run8(8'h05, 8'h03, 8'h02, 1'b0, "5-3");
    run8(8'h00, 8'h00, 8'h00, 1'b0, "0-0");
    run8(8'hFF, 8'hFF, 8'h00, 1'b0, "FF-FF");
    run8(8'h00, 8'hFF, 8'h01, 1'b1, "00-FF");
    run8(8'h03, 8'h05, 8'hFE, 1'b1, "3-5");

    // start pulse mid-operation must be ignored
    a8 = 8'h80; b8 = 8'h01; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    a8 = 8'h10; b8 = 8'h10; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    check("ign.busy", 32'(busy8), 32'd1);
    check("ign.diff_held", 32'(diff8), 32'hFE);
    ndone = 0; dpos = -1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done8) begin ndone++; dpos = i; end
    end
    check("ign.ndone", 32'(ndone), 32'd1);
    check("ign.dpos", 32'(dpos), 32'd4);
    check("ign.diff", 32'(diff8), 32'h7F);
    check("ign.borrow", 32'(bo8), 32'd0);
    check("ign.busy_end", 32'(busy8), 32'd0);

    // reset mid-shift aborts
    a8 = 8'h12; b8 = 8'h34; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("arst.busy", 32'(busy8), 32'd0);
    check("arst.done", 32'(done8), 32'd0);
    check("arst.diff", 32'(diff8), 32'd0);
    check("arst.borrow", 32'(bo8), 32'd0);
    any_done = 0;
    repeat (3) begin @(posedge clk); #1; if (done8) any_done = 1; end
    rst_n = 1'b1;
    repeat (12) begin @(posedge clk); #1; if (done8 || busy8) any_done = 1; end
    check("arst.no_done", 32'(any_done), 32'd0);
    run8(8'h0A, 8'h04, 8'h06, 1'b0, "0A-04");

    // back-to-back sweep, WIDTH=8
    ea8 = 8'($urandom); eb8 = 8'($urandom);
    a8 = ea8; b8 = eb8; start8 = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      seen = 0; gap = 0;
      while (!seen && gap < 16) begin
        @(posedge clk); #1;
        gap++;
        if (done8) seen = 1;
      end
      check("sw8.gap", 32'(gap), (i == 0) ? 32'd9 : 32'd10);
      check("sw8.diff", 32'(diff8), 32'(8'(ea8 - eb8)));
      check("sw8.borrow", 32'(bo8), 32'(ea8 < eb8));
      ea8 = 8'($urandom); eb8 = 8'($urandom);
      a8 = ea8; b8 = eb8;
    end
    start8 = 1'b0;

    // back-to-back sweep, WIDTH=13
    ea13 = 13'($urandom); eb13 = 13'($urandom);
    a13 = ea13; b13 = eb13; start13 = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      seen = 0; gap = 0;
      while (!seen && gap < 24) begin
        @(posedge clk); #1;
        gap++;
        if (done13) seen = 1;
      end
      check("sw13.gap", 32'(gap), (i == 0) ? 32'd14 : 32'd15);
      check("sw13.diff", 32'(diff13), 32'(13'(ea13 - eb13)));
      check("sw13.borrow", 32'(bo13), 32'(ea13 < eb13));
      ea13 = 13'($urandom); eb13 = 13'($urandom);
      a13 = ea13; b13 = eb13;
    end
    start13 = 1'b0;
    repeat (20) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
